// File: rtl/lynxTypes.sv
// Shared AXI4-Stream types for the register-slice family: default data width,
// the packed payload word and the per-slice occupancy states.
package lynxTypes;

    localparam int AXI_DATA_BITS = 64;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0]   data;
        logic [AXI_DATA_BITS/8-1:0] keep;
        logic                       last;
    } axis_word_t;

    typedef enum logic [1:0] {
        SLICE_EMPTY,
        SLICE_PART,
        SLICE_FULL
    } slice_state_t;

    // Width of one {data, keep, last} word for an arbitrary data width.
    function automatic int payload_bits(input int data_bits);
        return data_bits + data_bits / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_reg_array_skid_slice.sv
// One AXI4-Stream skid slice: main entry drives the output, skid entry absorbs the
// beat that arrives while the registered ready is still high. Every output is a flop.
module axis_skid_slice
    import lynxTypes::*;
#(
    parameter int PAYLOAD_BITS = payload_bits(AXI_DATA_BITS)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PAYLOAD_BITS-1:0] in_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PAYLOAD_BITS-1:0] out_payload
);

    slice_state_t            state;
    slice_state_t            state_next;
    logic [PAYLOAD_BITS-1:0] main_q;
    logic [PAYLOAD_BITS-1:0] skid_q;
    logic                    ready_q;
    logic                    xfer_in;
    logic                    xfer_out;
    logic                    load_main_in;
    logic                    load_main_skid;
    logic                    load_skid;

    assign xfer_in  = in_valid & ready_q;
    assign xfer_out = (state != SLICE_EMPTY) & out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            SLICE_EMPTY: begin
                if (xfer_in) begin
                    state_next   = SLICE_PART;
                    load_main_in = 1'b1;
                end
            end
            SLICE_PART: begin
                if (xfer_in && xfer_out) begin
                    load_main_in = 1'b1;
                end else if (xfer_in) begin
                    state_next = SLICE_FULL;
                    load_skid  = 1'b1;
                end else if (xfer_out) begin
                    state_next = SLICE_EMPTY;
                end
            end
            SLICE_FULL: begin
                if (xfer_out) begin
                    state_next     = SLICE_PART;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = SLICE_EMPTY;
        endcase
    end

    // Ready is precomputed from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= SLICE_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != SLICE_FULL);
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = (state != SLICE_EMPTY);
    assign out_payload = main_q;

endmodule

// File: rtl/axis_reg_array_skid.sv
// Chain of N_STAGES AXI4-Stream skid slices for crossing long, timing-critical routes
// at full throughput with every handshake signal registered at each stage.
module axis_reg_array_skid
    import lynxTypes::*;
#(
    parameter int N_STAGES  = 2,
    parameter int DATA_BITS = AXI_DATA_BITS
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast
);

    localparam int PAYLOAD_BITS = payload_bits(DATA_BITS);

    if (N_STAGES < 1) begin : g_bad_stages
        $error("axis_reg_array_skid: N_STAGES must be at least 1");
    end
    if (DATA_BITS % 8 != 0) begin : g_bad_width
        $error("axis_reg_array_skid: DATA_BITS must be a multiple of 8");
    end

    logic [N_STAGES:0]       valid_chain;
    logic [N_STAGES:0]       ready_chain;
    logic [PAYLOAD_BITS-1:0] payload_chain [0:N_STAGES];

    assign valid_chain[0]          = s_axis_tvalid;
    assign payload_chain[0]        = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign s_axis_tready           = ready_chain[0];
    assign m_axis_tvalid           = valid_chain[N_STAGES];
    assign ready_chain[N_STAGES]   = m_axis_tready;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = payload_chain[N_STAGES];

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        axis_skid_slice #(
            .PAYLOAD_BITS(PAYLOAD_BITS)
        ) u_slice (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .in_valid   (valid_chain[i]),
            .in_ready   (ready_chain[i]),
            .in_payload (payload_chain[i]),
            .out_valid  (valid_chain[i+1]),
            .out_ready  (ready_chain[i+1]),
            .out_payload(payload_chain[i+1])
        );
    end

endmodule
